// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot loader: the frame header, the FSM
// state encodings and the default timing and size parameters.
package uart_boot_pkg;

    // First byte of every boot frame.
    localparam logic [7:0] HEADER = 8'hA5;

    // 100 MHz clock at 115200 baud.
    localparam int DEFAULT_CLK_DIV = 868;

    // Largest image accepted, in 32-bit words.
    localparam int DEFAULT_MAX_WORDS = 1024;

    // Frame-level loader states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } boot_state_t;

    // Byte receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True while a frame is in progress. Only these states observe
    // framing errors and the inter-byte timeout.
    function automatic logic in_frame(boot_state_t s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a two-flop input synchronizer.
//
// Output handshake: byte_valid is a one-cycle strobe with byte_data
// stable in the same cycle; there is no ready, so the consumer must take
// the byte on the strobe. frame_err is a one-cycle strobe raised instead
// of byte_valid when the stop bit samples low. The two never coincide.
module uart_rx_byte
    import uart_boot_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q;
    logic [7:0]      byte_data_q;
    logic            frame_err_q;

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

    // Synchronize the line and keep one extra stage for falling-edge detection;
    // everything resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit-timing FSM: start re-check at half a bit, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        // A line already back high was a glitch, not a start bit.
                        if (!rx_sync_q) begin
                            state_q   <= RX_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image over an 8N1 line,
// writes it word by word into instruction memory, verifies an XOR checksum
// and releases the CPU from reset only after a fully good load.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int CLK_DIV        = DEFAULT_CLK_DIV,
    parameter int MAX_WORDS      = DEFAULT_MAX_WORDS,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_rx,
    output logic        ins_mem_wenb,
    output logic [31:0] ins_mem_waddr,
    output logic [31:0] ins_mem_wdata,
    output logic        cpu_resetn,
    output logic        done,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   MAX_N    = 16'(MAX_WORDS);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    boot_state_t state_q;
    logic [7:0]  cnt_lo_q;
    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] shift_q;
    logic [7:0]  csum_q;
    logic [TW-1:0] tmo_q;
    logic        wenb_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        cpu_resetn_q;
    logic        done_q;
    logic        error_q;

    logic [15:0] count_w;
    logic [31:0] word_w;
    logic        timed_out;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (ser_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Candidate word count and word, formed from the byte arriving this cycle.
    assign count_w   = {byte_data, cnt_lo_q};
    assign word_w    = {byte_data, shift_q[31:8]};
    assign timed_out = (tmo_q == TMO_LAST) && !byte_valid;

    assign ins_mem_wenb  = wenb_q;
    assign ins_mem_waddr = waddr_q;
    assign ins_mem_wdata = wdata_q;
    assign cpu_resetn    = cpu_resetn_q;
    assign done          = done_q;
    assign error         = error_q;

    // Frame FSM with registered outputs and the inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_lo_q     <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            wenb_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_resetn_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wenb_q <= 1'b0;

            // The gap counter runs only inside a frame and restarts on each byte.
            if (byte_valid || !in_frame(state_q)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (in_frame(state_q) && (frame_err || timed_out)) begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_valid && (byte_data == HEADER)) begin
                            state_q    <= S_CNT_LO;
                            idx_q      <= '0;
                            csum_q     <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                    S_CNT_LO: begin
                        if (byte_valid) begin
                            cnt_lo_q <= byte_data;
                            state_q  <= S_CNT_HI;
                        end
                    end
                    S_CNT_HI: begin
                        if (byte_valid) begin
                            if ((count_w != 16'd0) && (count_w <= MAX_N)) begin
                                n_q     <= count_w;
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_valid) begin
                            csum_q     <= csum_q ^ byte_data;
                            shift_q    <= word_w;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            // Fourth byte completes a little-endian word: issue its write.
                            if (byte_cnt_q == 2'd3) begin
                                wenb_q  <= 1'b1;
                                waddr_q <= {14'd0, idx_q, 2'b00};
                                wdata_q <= word_w;
                                idx_q   <= idx_q + 16'd1;
                                if ((idx_q + 16'd1) == n_q) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (byte_valid) begin
                            if (byte_data == csum_q) begin
                                state_q      <= S_DONE;
                                done_q       <= 1'b1;
                                cpu_resetn_q <= 1'b1;
                            end else begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        // Terminal until reset; the line is ignored.
                    end
                    S_ERROR: begin
                        if (byte_valid && (byte_data == HEADER)) begin
                            state_q    <= S_CNT_LO;
                            error_q    <= 1'b0;
                            idx_q      <= '0;
                            csum_q     <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
